line_mem_ctrl: RTL and testbench
================================

Name: line_mem_ctrl

Overview:
- Main-memory controller directly downstream of the write-back cache.
- Accepts the cache's line-wide requests (mreq/mwrite/maddr/mdata, ackm_n) and services them from a word-wide synchronous RAM as a burst, after a fixed first-access latency.
- Decodes the stdout and exit addresses as memory-mapped I/O.
- Provides a word-wide preload port for program loading and access counters for miss-penalty statistics.

Parameters:
- mdata_width, 256, line data bus width; equals block_size*8.
- addr_width, 32, address width.
- word_width, 32, backing RAM word width; mdata_width must be a multiple of it.
- words_per_line, mdata_width/word_width (8), burst beats per line; derived.
- mem_words, 65536, RAM depth in words (256 KiB).
- first_latency, 8, idle cycles before the first beat; must be ≥1.
- stdout_addr, 32'hf000_0000, character output address.
- exit_addr, 32'hff00_0000, simulation end address.

Ports:
- clk, input, 1, clock.
- rst, input, 1, reset.
- mreq, input, 1, memory request from cache.
- mwrite, input, 1, 1 = line write, 0 = line read.
- maddr, input, addr_width, line address; low log2(mdata_width/8) bits are zero.
- mdata, inout, mdata_width, line data; byte at line offset 0 is mdata[mdata_width-1 -: 8] (big-endian lane order).
- ackm_n, output, 1, active-low completion, exactly one cycle.
- ld_we, input, 1, preload write strobe, honoured only in IDLE.
- ld_addr, input, addr_width, preload byte address (word aligned).
- ld_data, input, word_width, preload word.
- stdout_valid, output, 1, one-cycle pulse: character written.
- stdout_char, output, 8, character = mdata[7:0] of the stdout write.
- exit_done, output, 1, sticky; set by a write to exit_addr.
- rd_count, output, 32, completed line reads.
- wr_count, output, 32, completed line writes.

Behaviour:
- Reset: rst is synchronous and active-high (applied at posedge clk).
  - Outputs on reset: ackm_n=1, mdata=Z, stdout_valid=0, stdout_char=0, exit_done=0, rd_count=0, wr_count=0; state=IDLE.
  - RAM contents are not cleared.
  - Reset mid-burst aborts silently with no ack; write beats already committed stay in RAM.
- States: IDLE, WAIT, BURST, ACK, MMIO.
- IDLE, sampling mreq=1:
  - maddr==stdout_addr with mwrite=1 → MMIO; stdout_char<=mdata[7:0].
  - maddr==exit_addr with mwrite=1 → MMIO; exit_done<=1.
  - Otherwise → WAIT; latch the line index (maddr bits above the byte offset, taken modulo mem_words/words_per_line, so addresses wrap).
  - If mwrite=1, also capture mdata into the line buffer.
- WAIT: count first_latency cycles, then → BURST with beat=0.
- BURST, write: write line-buffer word beat (word 0 = most significant word) each cycle; after words_per_line beats → ACK.
- BURST, read: issue RAM read beat i each cycle; RAM read latency is 1, so word i is captured the following cycle. One drain cycle after the last issue → ACK.
- ACK and MMIO: ackm_n=0 for exactly one cycle, then → IDLE.
  - Read ACK: line buffer driven on mdata during the ACK cycle only, and only when mwrite=0; mdata is Z in all other cycles.
  - Counters increment in their ACK cycle; stdout_valid pulses in the MMIO cycle.
- Latency, counted from the posedge that samples the request to the cycle where ackm_n=0:
  - read: first_latency+words_per_line+2 = 18 with defaults.
  - write: first_latency+words_per_line+1 = 17 with defaults.
  - MMIO: 1.
- New requests are sampled only in IDLE, never in the ACK cycle. This makes the cache's write-back→refill sequence (mreq held high, mwrite and maddr changed at the ack edge) a fresh request one cycle later.
- mreq falling before ACK aborts to IDLE with no ack and no counter change.
- MMIO writes never touch RAM. A read request to stdout_addr or exit_addr is treated as an ordinary RAM read at the wrapped address.
- ld_we outside IDLE is ignored. A preload and mreq in the same IDLE cycle: preload writes and the request is also accepted (the RAM port is free that cycle).

Decomposition:
- Shared package `mem_pkg`: SIZE_*/width constants, stdout/exit address constants, state encoding localparams.
- One sub-module, `mem_word_ram`: single-port word_width×mem_words RAM with synchronous write and 1-cycle synchronous read.

Test Plan:
- Preload words 0x0000_0000..0x0000_001C with 0x11111111..0x88888888, then read line 0x0 → ackm_n low at cycle 18, mdata=0x11111111_22222222_…_88888888, rd_count=1.
- Write line 0x40 with data 0xA5A5… (all 0xA5 bytes), then read 0x40 → write ack at cycle 17, read returns identical 256-bit value, wr_count=1.
- Write-back then refill, mreq held high (write 0x80, then at the ack edge switch to a read of 0x100) → two distinct acks, read accepted the cycle after the first ack, rd_count=1, wr_count=1.
- Write to stdout_addr with mdata[7:0]=0x41 → ackm_n low and stdout_valid high 1 cycle later, stdout_char=0x41, RAM unchanged.
- Write to exit_addr → exit_done=1 and stays 1; rst pulse → exit_done=0.
- Reset asserted during BURST of a read → ackm_n stays 1, mdata Z, rd_count=0; the next read completes normally with latency 18.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared sizing, MMIO address and state-encoding definitions for the main-memory
// controller and its backing RAM.
package mem_pkg;

  localparam int unsigned SIZE_LINE_BITS = 256;
  localparam int unsigned SIZE_ADDR_BITS = 32;
  localparam int unsigned SIZE_WORD_BITS = 32;
  localparam int unsigned SIZE_MEM_WORDS = 65536;
  localparam int unsigned FIRST_LATENCY  = 8;

  localparam logic [31:0] STDOUT_ADDR = 32'hf000_0000;
  localparam logic [31:0] EXIT_ADDR   = 32'hff00_0000;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_WAIT  = 3'd1,
    S_BURST = 3'd2,
    S_ACK   = 3'd3,
    S_MMIO  = 3'd4
  } state_t;

endpackage

// File: rtl/mem_word_ram.sv
// Single-port word-wide RAM: synchronous write, registered read (one cycle of
// read latency). Contents are never cleared.
module mem_word_ram #(
  parameter int unsigned word_width = 32,
  parameter int unsigned mem_words  = 65536,
  localparam int unsigned AW        = $clog2(mem_words)
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [AW-1:0]         addr,
  input  logic [word_width-1:0] wdata,
  output logic [word_width-1:0] rdata
);

  logic [word_width-1:0] mem [mem_words];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end
    rdata <= mem[addr];
  end

endmodule

// File: rtl/line_mem_ctrl.sv
// Line-wide memory controller behind the write-back cache: bursts lines to and
// from a word RAM after a fixed first-access latency, plus stdout/exit MMIO.
module line_mem_ctrl
  import mem_pkg::*;
#(
  parameter int unsigned mdata_width   = SIZE_LINE_BITS,
  parameter int unsigned addr_width    = SIZE_ADDR_BITS,
  parameter int unsigned word_width    = SIZE_WORD_BITS,
  parameter int unsigned mem_words     = SIZE_MEM_WORDS,
  parameter int unsigned first_latency = FIRST_LATENCY,
  parameter logic [addr_width-1:0] stdout_addr = STDOUT_ADDR,
  parameter logic [addr_width-1:0] exit_addr   = EXIT_ADDR
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   mreq,
  input  logic                   mwrite,
  input  logic [addr_width-1:0]  maddr,
  inout  wire  [mdata_width-1:0] mdata,
  output logic                   ackm_n,
  input  logic                   ld_we,
  input  logic [addr_width-1:0]  ld_addr,
  input  logic [word_width-1:0]  ld_data,
  output logic                   stdout_valid,
  output logic [7:0]             stdout_char,
  output logic                   exit_done,
  output logic [31:0]            rd_count,
  output logic [31:0]            wr_count
);

  localparam int unsigned words_per_line = mdata_width / word_width;
  localparam int unsigned RAM_AW         = $clog2(mem_words);
  localparam int unsigned BEAT_W         = $clog2(words_per_line) + 1;
  localparam int unsigned LINE_IDX_W     = RAM_AW - (BEAT_W - 1);
  localparam int unsigned LINE_OFF_W     = $clog2(mdata_width / 8);
  localparam int unsigned BYTE_OFF_W     = $clog2(word_width / 8);
  localparam int unsigned WAIT_W         = $clog2(first_latency + 1);

  state_t                  state;
  logic                    is_write;
  logic [WAIT_W-1:0]       wait_cnt;
  logic [BEAT_W-1:0]       beat;
  logic [BEAT_W-2:0]       beat_idx;
  logic [LINE_IDX_W-1:0]   line_idx;
  logic [word_width-1:0]   line_words [words_per_line];
  logic [mdata_width-1:0]  line_out;

  logic                    rd_vld_p1;
  logic [BEAT_W-2:0]       rd_idx_p1;

  logic                    ram_we;
  logic [RAM_AW-1:0]       ram_addr;
  logic [word_width-1:0]   ram_wdata;
  logic [word_width-1:0]   ram_rdata;

  logic                    unused_bits;

  assign beat_idx    = beat[BEAT_W-2:0];
  assign unused_bits = ^{maddr[LINE_OFF_W-1:0], maddr[addr_width-1:LINE_OFF_W+LINE_IDX_W],
                         ld_addr[BYTE_OFF_W-1:0], ld_addr[addr_width-1:BYTE_OFF_W+RAM_AW]};

  // Word 0 of the line is the most significant word on the bus.
  always_comb begin
    line_out = '0;
    for (int k = 0; k < words_per_line; k++) begin
      line_out[mdata_width-1-k*word_width -: word_width] = line_words[k];
    end
  end

  assign mdata = (state == S_ACK && !is_write && !mwrite) ? line_out : 'z;

  // The RAM port belongs to preload in IDLE and to the burst otherwise.
  always_comb begin
    ram_we    = 1'b0;
    ram_addr  = ld_addr[BYTE_OFF_W +: RAM_AW];
    ram_wdata = ld_data;
    case (state)
      S_IDLE: ram_we = ld_we;
      S_BURST: begin
        ram_addr  = {line_idx, beat_idx};
        ram_wdata = line_words[beat_idx];
        ram_we    = is_write && mreq;
      end
      default: ;
    endcase
    if (rst) begin
      ram_we = 1'b0;
    end
  end

  mem_word_ram #(
    .word_width(word_width),
    .mem_words (mem_words)
  ) u_ram (
    .clk  (clk),
    .we   (ram_we),
    .addr (ram_addr),
    .wdata(ram_wdata),
    .rdata(ram_rdata)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= S_IDLE;
      ackm_n       <= 1'b1;
      stdout_valid <= 1'b0;
      stdout_char  <= 8'h00;
      exit_done    <= 1'b0;
      rd_count     <= 32'd0;
      wr_count     <= 32'd0;
      wait_cnt     <= '0;
      beat         <= '0;
      rd_vld_p1    <= 1'b0;
    end else begin
      ackm_n       <= 1'b1;
      stdout_valid <= 1'b0;
      rd_vld_p1    <= 1'b0;
      case (state)
        S_IDLE: begin
          if (mreq) begin
            is_write <= mwrite;
            if (mwrite && maddr == stdout_addr) begin
              state        <= S_MMIO;
              ackm_n       <= 1'b0;
              stdout_valid <= 1'b1;
              stdout_char  <= mdata[7:0];
            end else if (mwrite && maddr == exit_addr) begin
              state     <= S_MMIO;
              ackm_n    <= 1'b0;
              exit_done <= 1'b1;
            end else begin
              state    <= S_WAIT;
              wait_cnt <= '0;
            end
          end
        end
        S_WAIT: begin
          if (!mreq) begin
            state <= S_IDLE;
          end else if (wait_cnt == WAIT_W'(first_latency - 1)) begin
            state <= S_BURST;
            beat  <= '0;
          end else begin
            wait_cnt <= wait_cnt + WAIT_W'(1);
          end
        end
        S_BURST: begin
          if (!mreq) begin
            state <= S_IDLE;
          end else if (is_write) begin
            if (beat == BEAT_W'(words_per_line - 1)) begin
              state  <= S_ACK;
              ackm_n <= 1'b0;
            end else begin
              beat <= beat + BEAT_W'(1);
            end
          end else begin
            // Last issue is followed by one drain cycle for the RAM read latency.
            if (beat == BEAT_W'(words_per_line)) begin
              state  <= S_ACK;
              ackm_n <= 1'b0;
            end else begin
              rd_vld_p1 <= 1'b1;
              beat      <= beat + BEAT_W'(1);
            end
          end
        end
        S_ACK: begin
          state <= S_IDLE;
          if (is_write) begin
            wr_count <= wr_count + 32'd1;
          end else begin
            rd_count <= rd_count + 32'd1;
          end
        end
        S_MMIO: state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  // p0 -> p1: read address issued; RAM word lands in the line buffer next cycle.
  always_ff @(posedge clk) begin
    if (state == S_IDLE && mreq) begin
      line_idx <= maddr[LINE_OFF_W +: LINE_IDX_W];
      if (mwrite) begin
        for (int k = 0; k < words_per_line; k++) begin
          line_words[k] <= mdata[mdata_width-1-k*word_width -: word_width];
        end
      end
    end
    if (state == S_BURST) begin
      rd_idx_p1 <= beat_idx;
    end
    if (rd_vld_p1) begin
      line_words[rd_idx_p1] <= ram_rdata;
    end
  end

endmodule

// File: tb/tb_line_mem_ctrl.sv
// Directed bench for line_mem_ctrl: table of line requests with hand-computed
// latency/data/counter expectations, plus multi-cycle corner-case sequences.
module tb_line_mem_ctrl;

  logic         clk = 1'b0;
  logic         rst, mreq, mwrite, ld_we, tb_oe;
  logic [31:0]  maddr, ld_addr, ld_data;
  logic [255:0] tb_mdata;
  wire  [255:0] mdata;
  logic         ackm_n, stdout_valid, exit_done;
  logic [7:0]   stdout_char;
  logic [31:0]  rd_count, wr_count;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  assign mdata = tb_oe ? tb_mdata : 'z;

  line_mem_ctrl dut (
    .clk(clk), .rst(rst), .mreq(mreq), .mwrite(mwrite), .maddr(maddr), .mdata(mdata),
    .ackm_n(ackm_n), .ld_we(ld_we), .ld_addr(ld_addr), .ld_data(ld_data),
    .stdout_valid(stdout_valid), .stdout_char(stdout_char), .exit_done(exit_done),
    .rd_count(rd_count), .wr_count(wr_count)
  );

  typedef struct {
    bit           wr;
    logic [31:0]  addr;
    logic [255:0] wdata;
    int           lat;
    logic [255:0] rdata;
    bit           chk_rd;
    int           rd;
    int           wrc;
    bit           exit_d;
    bit           sv;
    logic [7:0]   ch;
  } vec_t;

  vec_t vecs [10];

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic preload(input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    ld_we = 1'b1; ld_addr = a; ld_data = d;
    @(posedge clk); #1;
    ld_we = 1'b0;
  endtask

  task automatic wait_ack(output int lat);
    lat = 0;
    do begin
      @(posedge clk); #1;
      lat++;
    end while (ackm_n && lat < 60);
    if (ackm_n) lat = -1;
  endtask

  task automatic do_req(input bit wr, input logic [31:0] a, input logic [255:0] d,
                        output int lat, output logic [255:0] rdat, output logic sv);
    @(negedge clk);
    mreq = 1'b1; mwrite = wr; maddr = a; tb_mdata = d; tb_oe = wr;
    wait_ack(lat);
    rdat = mdata;
    sv   = stdout_valid;
    mreq = 1'b0; mwrite = 1'b0; tb_oe = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [255:0] l0, l100, a5, pat, q, rdat;
    logic         sv, ack_seen;
    int           lat;

    l0   = {32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444,
            32'h55555555, 32'h66666666, 32'h77777777, 32'h88888888};
    l100 = {32'hC0DE0000, 32'hC0DE0001, 32'hC0DE0002, 32'hC0DE0003,
            32'hC0DE0004, 32'hC0DE0005, 32'hC0DE0006, 32'hC0DE0007};
    a5   = {32{8'hA5}};
    pat  = 256'h0123456789ABCDEF_FEDCBA9876543210_0F1E2D3C4B5A6978_8796A5B4C3D2E1F0;
    q    = {4{64'h5A5A0000FFFF1234}};

    rst = 1'b1; mreq = 1'b0; mwrite = 1'b0; maddr = '0; tb_mdata = '0; tb_oe = 1'b0;
    ld_we = 1'b0; ld_addr = '0; ld_data = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_ackm_n", 256'(ackm_n), 256'(1'b1));
    check("rst_stdout_valid", 256'(stdout_valid), 256'(1'b0));
    check("rst_stdout_char", 256'(stdout_char), 256'h0);
    check("rst_exit_done", 256'(exit_done), 256'(1'b0));
    check("rst_rd_count", 256'(rd_count), 256'h0);
    check("rst_wr_count", 256'(wr_count), 256'h0);
    @(negedge clk);
    rst = 1'b0;

    for (int k = 0; k < 8; k++) begin
      preload(32'(4 * k), 32'h11111111 * 32'(k + 1));
      preload(32'h100 + 32'(4 * k), 32'hC0DE0000 + 32'(k));
    end

    //          wr    addr           wdata                lat rdata  chk  rd wr exit sv  ch
    vecs[0] = '{1'b0, 32'h0000_0000, 256'h0,              18, l0,    1'b1, 1, 0, 1'b0, 1'b0, 8'h00};
    vecs[1] = '{1'b1, 32'h0000_0040, a5,                  17, 256'h0, 1'b0, 1, 1, 1'b0, 1'b0, 8'h00};
    vecs[2] = '{1'b0, 32'h0000_0040, 256'h0,              18, a5,    1'b1, 2, 1, 1'b0, 1'b0, 8'h00};
    vecs[3] = '{1'b0, 32'h0004_0040, 256'h0,              18, a5,    1'b1, 3, 1, 1'b0, 1'b0, 8'h00};
    vecs[4] = '{1'b1, 32'h0000_0080, pat,                 17, 256'h0, 1'b0, 3, 2, 1'b0, 1'b0, 8'h00};
    vecs[5] = '{1'b0, 32'h0000_0080, 256'h0,              18, pat,   1'b1, 4, 2, 1'b0, 1'b0, 8'h00};
    vecs[6] = '{1'b1, 32'hF000_0000, {a5[255:8], 8'h41},   1, 256'h0, 1'b0, 4, 2, 1'b0, 1'b1, 8'h41};
    vecs[7] = '{1'b0, 32'hF000_0000, 256'h0,              18, l0,    1'b1, 5, 2, 1'b0, 1'b0, 8'h41};
    vecs[8] = '{1'b1, 32'hFF00_0000, a5,                   1, 256'h0, 1'b0, 5, 2, 1'b1, 1'b0, 8'h41};
    vecs[9] = '{1'b0, 32'h0000_0000, 256'h0,              18, l0,    1'b1, 6, 2, 1'b1, 1'b0, 8'h41};

    for (int i = 0; i < 10; i++) begin
      do_req(vecs[i].wr, vecs[i].addr, vecs[i].wdata, lat, rdat, sv);
      check($sformatf("v%0d_latency", i), 256'(lat), 256'(vecs[i].lat));
      if (vecs[i].chk_rd) check($sformatf("v%0d_rdata", i), rdat, vecs[i].rdata);
      check($sformatf("v%0d_stdout_valid", i), 256'(sv), 256'(vecs[i].sv));
      check($sformatf("v%0d_stdout_char", i), 256'(stdout_char), 256'(vecs[i].ch));
      check($sformatf("v%0d_exit_done", i), 256'(exit_done), 256'(vecs[i].exit_d));
      check($sformatf("v%0d_rd_count", i), 256'(rd_count), 256'(vecs[i].rd));
      check($sformatf("v%0d_wr_count", i), 256'(wr_count), 256'(vecs[i].wrc));
    end

    pulse_reset();
    check("rst2_exit_done", 256'(exit_done), 256'(1'b0));
    check("rst2_rd_count", 256'(rd_count), 256'h0);
    check("rst2_wr_count", 256'(wr_count), 256'h0);

    // Write-back followed by refill with mreq held high across the ack.
    @(negedge clk);
    mreq = 1'b1; mwrite = 1'b1; maddr = 32'h80; tb_mdata = q; tb_oe = 1'b1;
    wait_ack(lat);
    check("wb_latency", 256'(lat), 256'd17);
    mwrite = 1'b0; maddr = 32'h100; tb_oe = 1'b0;
    wait_ack(lat);
    check("refill_latency", 256'(lat), 256'd19);
    check("refill_rdata", mdata, l100);
    mreq = 1'b0;
    @(posedge clk); #1;
    check("refill_rd_count", 256'(rd_count), 256'd1);
    check("refill_wr_count", 256'(wr_count), 256'd1);
    do_req(1'b0, 32'h80, 256'h0, lat, rdat, sv);
    check("wb_readback", rdat, q);
    check("wb_readback_rd_count", 256'(rd_count), 256'd2);

    // Reset during a read burst: no ack, counters cleared, next read normal.
    @(negedge clk);
    mreq = 1'b1; mwrite = 1'b0; maddr = 32'h0;
    ack_seen = 1'b0;
    repeat (12) begin
      @(posedge clk); #1;
      if (!ackm_n) ack_seen = 1'b1;
    end
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; mreq = 1'b0;
    repeat (25) begin
      @(posedge clk); #1;
      if (!ackm_n) ack_seen = 1'b1;
    end
    check("burst_rst_no_ack", 256'(ack_seen), 256'(1'b0));
    check("burst_rst_rd_count", 256'(rd_count), 256'h0);
    do_req(1'b0, 32'h0, 256'h0, lat, rdat, sv);
    check("post_rst_latency", 256'(lat), 256'd18);
    check("post_rst_rdata", rdat, l0);
    check("post_rst_rd_count", 256'(rd_count), 256'd1);

    // mreq dropped during WAIT: aborted, no ack, no count.
    @(negedge clk);
    mreq = 1'b1; mwrite = 1'b0; maddr = 32'h40;
    ack_seen = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    mreq = 1'b0;
    repeat (25) begin
      @(posedge clk); #1;
      if (!ackm_n) ack_seen = 1'b1;
    end
    check("abort_no_ack", 256'(ack_seen), 256'(1'b0));
    check("abort_rd_count", 256'(rd_count), 256'd1);

    // Preload strobe while busy is ignored.
    @(negedge clk);
    mreq = 1'b1; mwrite = 1'b0; maddr = 32'h40;
    @(posedge clk);
    @(negedge clk);
    ld_we = 1'b1; ld_addr = 32'h0; ld_data = 32'hDEADBEEF;
    @(posedge clk); #1;
    ld_we = 1'b0;
    wait_ack(lat);
    check("busy_ld_latency", 256'(lat), 256'd16);
    check("busy_ld_rdata", mdata, a5);
    mreq = 1'b0;
    @(posedge clk); #1;
    do_req(1'b0, 32'h0, 256'h0, lat, rdat, sv);
    check("busy_ld_ram_unchanged", rdat, l0);
    check("final_rd_count", 256'(rd_count), 256'd3);
    check("final_wr_count", 256'(wr_count), 256'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
